// File: rtl/hires_dtc_if.sv
// rtl/hires_dtc_if.sv - interval-word write port of hires_dtc
// Producer (master) drives time_in/time_wr; the DTC (slave) answers with time_rdy.
interface hires_dtc_if #(
  parameter int W = 8
);
  logic [W-1:0] time_in;
  logic         time_wr;
  logic         time_rdy;

  modport master (output time_in, output time_wr, input time_rdy);
  modport slave  (input time_in, input time_wr, output time_rdy);
endinterface

// File: rtl/hires_dtc.sv
// rtl/hires_dtc.sv - digital-to-time pulse generator with queued {coarse, fine} intervals
// HIRES_DTC_QUEUE_EN builds the QUEUE_DEPTH-entry queue; otherwise one holding register.
module hires_dtc #(
  parameter int COARSE_BIT  = 4,
  parameter int FINE_BIT    = 4,
  parameter int PULSE_WIDTH = 2,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rstb_i,
  hires_dtc_if.slave          tif,
  input  logic                start_i,
  output logic                stop_out_o,
  output logic [FINE_BIT-1:0] fine_sel_o,
  output logic                busy_o,
  output logic                empty_o,
  output logic                miss_o
);
  localparam int W = COARSE_BIT + FINE_BIT;
  localparam logic [3:0] PW_M1 = 4'(PULSE_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_COUNT, S_PULSE} state_t;

  state_t                state_q, state_d;
  logic [COARSE_BIT-1:0] cnt_q, cnt_d;
  logic [3:0]            pcnt_q, pcnt_d;
  logic                  stop_q, stop_d;
  logic [FINE_BIT-1:0]   fine_q, fine_d;
  logic                  miss_q, miss_d;
  logic                  old_start_q;

  logic                  start_edge;
  logic                  wr_fire;
  logic                  pop;
  logic                  q_empty;
  logic [W-1:0]          head;

  assign start_edge = start_i & ~old_start_q;
  assign wr_fire    = tif.time_wr & tif.time_rdy;

`ifdef HIRES_DTC_QUEUE_EN
  localparam int AW = $clog2(QUEUE_DEPTH);

  logic [W-1:0] mem_q [QUEUE_DEPTH];
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic         q_full;

  // Extra pointer bit separates full from empty when the address bits match.
  assign q_empty      = (wr_ptr_q == rd_ptr_q);
  assign q_full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign tif.time_rdy = ~q_full;
  assign head         = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= tif.time_in;
  end
`else
  logic [W-1:0] hold_q;
  logic         hold_valid_q;

  assign q_empty      = ~hold_valid_q;
  assign tif.time_rdy = ~hold_valid_q;
  assign head         = hold_q;

  // A write needs an empty register and a pop needs a full one, so they never coincide.
  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else if (wr_fire) begin
      hold_q       <= tif.time_in;
      hold_valid_q <= 1'b1;
    end else if (pop) begin
      hold_valid_q <= 1'b0;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    stop_d  = stop_q;
    fine_d  = fine_q;
    miss_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        miss_d = start_edge;
        if (!q_empty || wr_fire) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (start_edge) begin
          pop     = 1'b1;
          cnt_d   = head[W-1:FINE_BIT];
          fine_d  = head[FINE_BIT-1:0];
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        miss_d = start_edge;
        if (cnt_q == '0) begin
          state_d = S_PULSE;
          stop_d  = 1'b1;
          pcnt_d  = PW_M1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_PULSE: begin
        miss_d = start_edge;
        if (pcnt_q == '0) begin
          stop_d  = 1'b0;
          state_d = (!q_empty || wr_fire) ? S_ARMED : S_IDLE;
        end else begin
          pcnt_d = pcnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pcnt_q      <= '0;
      stop_q      <= 1'b0;
      fine_q      <= '0;
      miss_q      <= 1'b0;
      old_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pcnt_q      <= pcnt_d;
      stop_q      <= stop_d;
      fine_q      <= fine_d;
      miss_q      <= miss_d;
      old_start_q <= start_i;
    end
  end

  assign stop_out_o = stop_q;
  assign fine_sel_o = fine_q;
  assign busy_o     = (state_q == S_COUNT) || (state_q == S_PULSE);
  assign empty_o    = q_empty;
  assign miss_o     = miss_q;
endmodule

// File: tb/tb_hires_dtc.sv
// tb/tb_hires_dtc.sv - directed self-checking bench for hires_dtc
// Inputs change and outputs are sampled on the falling clock edge.
module tb_hires_dtc;
  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       start = 1'b0;
  logic       stop_out;
  logic [3:0] fine_sel;
  logic       busy, empty, miss;
  int         checks = 0;
  int         errors = 0;

  hires_dtc_if #(.W(8)) tif ();

  hires_dtc #(.COARSE_BIT(4), .FINE_BIT(4), .PULSE_WIDTH(2), .QUEUE_DEPTH(4)) dut (
    .clk_i      (clk),
    .rstb_i     (rstb),
    .tif        (tif),
    .start_i    (start),
    .stop_out_o (stop_out),
    .fine_sel_o (fine_sel),
    .busy_o     (busy),
    .empty_o    (empty),
    .miss_o     (miss)
  );

  always #5 clk = ~clk;

  task automatic write_word(input logic [7:0] w);
    @(negedge clk);
    tif.time_in = w;
    tif.time_wr = 1'b1;
    @(negedge clk);
    tif.time_wr = 1'b0;
  endtask

  // Returns half a cycle after detection edge E (k = 0 in the pulse loops).
  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    tif.time_in = '0;
    tif.time_wr = 1'b0;
    rstb = 1'b0;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({tif.time_rdy, empty, stop_out, fine_sel, miss, busy} !== 9'b1_1_0_0000_0_0) begin
      errors++;
      $display("FAIL reset rdy/empty/stop/fine/miss/busy got %b required 110000000",
               {tif.time_rdy, empty, stop_out, fine_sel, miss, busy});
    end
  endtask

  task automatic test_coarse3();
    write_word(8'h3A);
    checks++;
    if (empty !== 1'b0) begin errors++; $display("FAIL c3_empty_after_write got %b required 0", empty); end
    start_pulse();
    for (int k = 0; k <= 7; k++) begin
      checks++;
      if (stop_out !== (k == 4 || k == 5)) begin
        errors++; $display("FAIL c3_stop k=%0d got %b required %b", k, stop_out, (k == 4 || k == 5));
      end
      if (k <= 5) begin
        checks++;
        if (fine_sel !== 4'hA) begin errors++; $display("FAIL c3_fine k=%0d got %h required a", k, fine_sel); end
      end
      if (k == 0) begin
        checks++;
        if (busy !== 1'b1 || miss !== 1'b0) begin
          errors++; $display("FAIL c3_busy_miss got %b%b required 10", busy, miss);
        end
      end
      @(negedge clk);
    end
    checks++;
    if ({empty, busy, fine_sel} !== 6'b1_0_1010) begin
      errors++; $display("FAIL c3_idle_after got %b required 101010", {empty, busy, fine_sel});
    end
  endtask

  task automatic test_coarse0();
    write_word(8'h05);
    start_pulse();
    for (int k = 0; k <= 4; k++) begin
      checks++;
      if (stop_out !== (k == 1 || k == 2)) begin
        errors++; $display("FAIL c0_stop k=%0d got %b required %b", k, stop_out, (k == 1 || k == 2));
      end
      @(negedge clk);
    end
    checks++;
    if (fine_sel !== 4'h5) begin errors++; $display("FAIL c0_fine got %h required 5", fine_sel); end
  endtask

`ifdef HIRES_DTC_QUEUE_EN
  task automatic test_queue_full();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tif.time_in = 8'h10 + 8'(i);
      tif.time_wr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tif.time_wr = 1'b0;
      checks++;
      if (tif.time_rdy !== (i < 3)) begin
        errors++; $display("FAIL q_rdy i=%0d got %b required %b", i, tif.time_rdy, (i < 3));
      end
    end
    for (int i = 0; i < 4; i++) begin
      start_pulse();
      for (int k = 0; k <= 4; k++) begin
        checks++;
        if (stop_out !== (k == 2 || k == 3) || fine_sel !== 4'(i) || miss !== 1'b0) begin
          errors++; $display("FAIL q_pulse i=%0d k=%0d stop/fine/miss got %b/%h/%b required %b/%h/0",
                             i, k, stop_out, fine_sel, miss, (k == 2 || k == 3), 4'(i));
        end
        if (k < 4) @(negedge clk);
      end
    end
    start_pulse();
    checks++;
    if (miss !== 1'b1 || empty !== 1'b1) begin
      errors++; $display("FAIL q_fifth_miss miss/empty got %b/%b required 1/1", miss, empty);
    end
  endtask
`else
  task automatic test_queue_full();
    write_word(8'h21);
    checks++;
    if (tif.time_rdy !== 1'b0) begin errors++; $display("FAIL h_rdy_full got %b required 0", tif.time_rdy); end
    write_word(8'h22);
    start_pulse();
    repeat (5) @(negedge clk);
    checks++;
    if (fine_sel !== 4'h1 || empty !== 1'b1) begin
      errors++; $display("FAIL h_drop fine/empty got %h/%b required 1/1", fine_sel, empty);
    end
    start_pulse();
    checks++;
    if (miss !== 1'b1) begin errors++; $display("FAIL h_miss got %b required 1", miss); end
  endtask
`endif

  task automatic test_miss_in_count();
    write_word(8'hF0);
    start_pulse();
    for (int k = 0; k <= 19; k++) begin
      checks++;
      if (stop_out !== (k == 16 || k == 17) || miss !== (k == 4)) begin
        errors++; $display("FAIL cnt_miss k=%0d stop/miss got %b/%b required %b/%b",
                           k, stop_out, miss, (k == 16 || k == 17), (k == 4));
      end
      if (k == 3) start = 1'b1;
      if (k == 4) start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_pulse();
    write_word(8'h27);
    start_pulse();
    write_word(8'h11);
    @(negedge clk);
    checks++;
    if (stop_out !== 1'b1) begin errors++; $display("FAIL rst_pre_stop got %b required 1", stop_out); end
    #1 rstb = 1'b0;
    #1;
    checks++;
    if (stop_out !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL rst_async stop/empty got %b/%b required 0/1", stop_out, empty);
    end
    @(negedge clk);
    rstb = 1'b1;
    start_pulse();
    checks++;
    if (miss !== 1'b1) begin errors++; $display("FAIL rst_then_miss got %b required 1", miss); end
  endtask

  initial begin
    test_reset();
    test_coarse3();
    test_coarse0();
    test_queue_full();
    test_miss_in_count();
    test_reset_mid_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hires_dtc.md
# hires_dtc

Digital-to-time pulse generator: the transmit-side counterpart of the high-resolution TDC. It accepts queued interval words made of a coarse part and a fine part, using the same format the TDC produces. On each START rising edge it emits a STOP_OUT pulse delayed by the coarse count in CLK cycles, and presents the fine part on FINE_SEL to steer the external tapped-delay mux. It sits beside the TDC in the timing path and is used for calibration loopback and test-pulse injection.

## Interface
- COARSE_BIT, 4, width of the coarse (clock-cycle) field
- FINE_BIT, 4, width of the fine (delay-tap select) field
- PULSE_WIDTH, 2, STOP_OUT high time in CLK cycles (1..15)
- QUEUE_DEPTH, 4, interval queue entries (power of 2, ≥2)
- CLK  in  1  single system clock; all logic on its rising edge
- RSTb  in  1  asynchronous active-low reset
- TIME_IN  in  COARSE_BIT+FINE_BIT  interval word {coarse, fine}
- TIME_WR  in  1  write strobe; accepted when TIME_WR & TIME_RDY
- TIME_RDY  out  1  queue can accept a word
- START  in  1  reference edge input, synchronous to CLK
- STOP_OUT  out  1  generated delayed pulse (registered)
- FINE_SEL  out  FINE_BIT  tap select for the external delay mux
- BUSY  out  1  high in COUNT or PULSE
- EMPTY  out  1  queue empty
- MISS  out  1  one-cycle pulse: START edge rejected

## Operation
- Edge detect: `old_start` is a registered copy of START. An edge is detected at edge E when START=1 and old_start=0.
- FSM states:
  - IDLE: queue empty.
  - ARMED: head entry valid, waiting for a START edge.
  - COUNT: down-counting the coarse field.
  - PULSE: STOP_OUT high.
- IDLE→ARMED when the queue becomes non-empty.
- ARMED + START edge at E:
  - Pop the head entry.
  - Load `cnt` ← coarse field and FINE_SEL ← fine field.
  - Enter COUNT.
- COUNT: when cnt=0, enter PULSE; otherwise cnt ← cnt−1.
- PULSE: STOP_OUT held high for PULSE_WIDTH cycles, then go to ARMED if the queue is non-empty, else IDLE.
- FINE_SEL is stable from E until STOP_OUT falls. It holds its last value while idle.
- MISS pulses for one cycle on a START edge in IDLE, COUNT or PULSE. That edge is otherwise ignored and the queue is untouched.
- Queue:
  - Circular buffer with read/write pointers one bit wider than the address; pointers wrap modulo 2·QUEUE_DEPTH.
  - TIME_RDY = not full.
  - A write while full is dropped silently.
  - A write and a pop in the same cycle are both performed, and the count is unchanged.
  - A write into an empty queue is visible as ARMED on the next cycle. A START edge in that same cycle gets MISS.

## Timing
- Reset values: STOP_OUT=0, FINE_SEL=0, BUSY=0, MISS=0, EMPTY=1, TIME_RDY=1. FSM=IDLE, queue cleared.
- Edge-to-pulse latency (C = coarse value, E = detection edge):
  - STOP_OUT rises after edge E+1+C.
  - STOP_OUT falls after edge E+1+C+PULSE_WIDTH.
- Back-to-back: the next START edge is accepted no earlier than the cycle STOP_OUT falls, and only if state is ARMED.
- RSTb asserted mid-pulse: STOP_OUT drops immediately (asynchronously) and all queued entries are lost.
- MISS is registered; it is high for the cycle after E.

## Configuration
- HIRES_DTC_QUEUE_EN: when defined, the QUEUE_DEPTH-entry queue is built.
- When undefined, a single holding register replaces the queue:
  - TIME_RDY = register empty.
  - QUEUE_DEPTH is ignored.
  - A write and a pop in the same cycle is not possible, because TIME_RDY is low while the register is full.
- FSM timing is identical in both builds.

## Test plan
- Reset release, no stimulus: TIME_RDY=1, EMPTY=1, STOP_OUT=0, FINE_SEL=0, MISS=0.
- Write 8'h3A, then START edge at E: FINE_SEL=4'hA from E+1; STOP_OUT high after edges E+4..E+5 (2 cycles); EMPTY=1 afterwards.
- Write 8'h05, then START edge: coarse 0, so STOP_OUT rises after E+1; FINE_SEL=4'h5.
- With the macro defined:
  - Write 5 words (0x10..0x14): the 5th is dropped and TIME_RDY=0 after the 4th.
  - Five START edges give four pulses with FINE_SEL 0..3 plus one MISS.
- START edge while in COUNT (word 8'hF0): MISS for one cycle, and the original pulse timing is unchanged at E+16.
- RSTb low during PULSE: STOP_OUT=0 immediately, EMPTY=1; a subsequent START edge gives MISS.
